merge_sweep_checker: RTL

MERGE_SWEEP_CHECKER -- requirements
Module: merge_sweep_checker

---
 rtl/merge_sweep_pkg.sv | 19 +
 rtl/merge_sweep_checker_if.sv | 30 +++
 rtl/merge_sweep_checker.sv | 95 +++++++++
 3 files changed

// File: rtl/merge_sweep_pkg.sv
// Shared types and sizes for the exhaustive 5-input function sweep checker.
package merge_sweep_pkg;

    localparam int VEC_W = 5;
    localparam int N_VEC = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Mismatch counter increment that sticks at N_VEC instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt >= CNT_W'(N_VEC)) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/merge_sweep_checker_if.sv
// Sweep control, stimulus vector, compared function outputs and results.
interface merge_sweep_checker_if;

    logic                                   start;
    logic [merge_sweep_pkg::VEC_W-1:0]      vec;
    logic                                   ref_out;
    logic                                   dut_out;
    logic                                   busy;
    logic                                   done;
    logic                                   pass;
    logic [merge_sweep_pkg::CNT_W-1:0]      mismatch_count;
    logic                                   fail_valid;
    logic [merge_sweep_pkg::VEC_W-1:0]      first_fail;
    logic [merge_sweep_pkg::N_VEC-1:0]      truth_table;

    // Environment side: requests sweeps and evaluates both functions on vec.
    modport master (
        output start, ref_out, dut_out,
        input  vec, busy, done, pass, mismatch_count,
               fail_valid, first_fail, truth_table
    );

    // Checker side.
    modport slave (
        input  start, ref_out, dut_out,
        output vec, busy, done, pass, mismatch_count,
               fail_valid, first_fail, truth_table
    );

endinterface

// File: rtl/merge_sweep_checker.sv
// Walks vec over all 32 inputs, comparing ref_out vs dut_out and recording the truth table.
// Done pulses 33 cycles after an accepted start; start is ignored while busy or done.
module merge_sweep_checker
    import merge_sweep_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    merge_sweep_checker_if.slave bus
);

    state_t             state_q;
    state_t             state_d;

    logic [VEC_W-1:0]   vec_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               fail_valid_q;
    logic [VEC_W-1:0]   first_fail_q;
    logic [N_VEC-1:0]   truth_q;
    logic               pass_q;

    logic               mism;
    logic               last_vec;

    assign mism     = bus.ref_out ^ bus.dut_out;
    assign last_vec = (vec_q == VEC_W'(N_VEC - 1));
    assign cnt_nxt  = mism ? sat_inc(cnt_q) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SWEEP;
            SWEEP:   if (last_vec)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q        <= '0;
            cnt_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            truth_q      <= '0;
            pass_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        vec_q        <= '0;
                        cnt_q        <= '0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= '0;
                        truth_q      <= '0;
                        pass_q       <= 1'b0;
                    end
                end
                SWEEP: begin
                    truth_q[vec_q] <= bus.ref_out;
                    // Natural 5-bit wrap returns vec to 0 on the final edge.
                    vec_q          <= vec_q + 1'b1;
                    cnt_q          <= cnt_nxt;
                    if (mism && !fail_valid_q) begin
                        fail_valid_q <= 1'b1;
                        first_fail_q <= vec_q;
                    end
                    if (last_vec) begin
                        pass_q <= (cnt_nxt == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.vec            = vec_q;
    assign bus.busy           = (state_q == SWEEP);
    assign bus.done           = (state_q == DONE);
    assign bus.pass           = pass_q;
    assign bus.mismatch_count = cnt_q;
    assign bus.fail_valid     = fail_valid_q;
    assign bus.first_fail     = first_fail_q;
    assign bus.truth_table    = truth_q;

endmodule
